// File: rtl/alu_muldiv_seq.sv
// Iterative RISC-V M-extension multiply/divide unit: one radix-2 step per clock,
// valid/ready handshake on request and result sides.
module alu_muldiv_seq #(
   parameter int N = 32
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic [2:0]   operacion_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [N-1:0] result_o,
   output logic         zeroflag_o,
   output logic         busy_o
);

   localparam int CW = $clog2(N + 1);
   localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state_reg, state_next;

   // hi/lo: product accumulator for multiply, remainder/quotient for divide.
   // m holds the multiplicand or divisor magnitude.
   logic [N-1:0]  hi_reg, hi_next;
   logic [N-1:0]  lo_reg, lo_next;
   logic [N-1:0]  m_reg, m_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [2:0]    op_reg, op_next;
   logic          neg_reg, neg_next;
   logic [N-1:0]  result_reg, result_next;
   logic          zero_reg, zero_next;

   logic         accept;
   logic         is_div_in;
   logic         a_signed_in, b_signed_in;
   logic         a_neg_in, b_neg_in;
   logic [N-1:0] a_mag_in, b_mag_in;
   logic         res_neg_in;
   logic         div_zero_in, ovf_in, special_in;
   logic [N-1:0] special_val;

   logic [N:0]     mul_sum;
   logic [N:0]     div_trial;
   logic [2*N-1:0] prod, prod_fix;
   logic [N-1:0]   quo_fix, rem_fix, fix_val;

   // Request decode: signedness per op, operand magnitudes and short-cut results.
   always_comb begin
      accept      = valid_i & (state_reg == IDLE);
      is_div_in   = operacion_i[2];
      a_signed_in = is_div_in ? ~operacion_i[0] : (operacion_i[1] ^ operacion_i[0]);
      b_signed_in = is_div_in ? ~operacion_i[0] : (operacion_i[1:0] == 2'b01);
      a_neg_in    = a_signed_in & a_i[N-1];
      b_neg_in    = b_signed_in & b_i[N-1];
      a_mag_in    = a_neg_in ? -a_i : a_i;
      b_mag_in    = b_neg_in ? -b_i : b_i;
      // Remainder follows the dividend sign; everything else is sign(a) xor sign(b).
      res_neg_in  = (is_div_in & operacion_i[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);
      div_zero_in = is_div_in & (b_i == '0);
      ovf_in      = is_div_in & ~operacion_i[0] & (a_i == MIN_NEG) & (b_i == '1);
      special_in  = div_zero_in | ovf_in;
      if (div_zero_in) begin
         special_val = operacion_i[1] ? a_i : '1;
      end else begin
         special_val = operacion_i[1] ? '0 : a_i;
      end
   end

   // Iteration step and final sign correction.
   always_comb begin
      mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, m_reg} : '0);
      div_trial = {hi_reg, lo_reg[N-1]} - {1'b0, m_reg};
      prod      = {hi_reg, lo_reg};
      prod_fix  = neg_reg ? -prod : prod;
      quo_fix   = neg_reg ? -lo_reg : lo_reg;
      rem_fix   = neg_reg ? -hi_reg : hi_reg;
      case (op_reg)
         3'd0:             fix_val = prod_fix[N-1:0];
         3'd1, 3'd2, 3'd3: fix_val = prod_fix[2*N-1:N];
         3'd4, 3'd5:       fix_val = quo_fix;
         default:          fix_val = rem_fix;
      endcase
   end

   always_comb begin
      hi_next     = hi_reg;
      lo_next     = lo_reg;
      m_next      = m_reg;
      cnt_next    = cnt_reg;
      op_next     = op_reg;
      neg_next    = neg_reg;
      result_next = result_reg;
      zero_next   = zero_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               op_next  = operacion_i;
               neg_next = res_neg_in;
               cnt_next = CW'(N);
               hi_next  = '0;
               if (is_div_in) begin
                  lo_next = a_mag_in;
                  m_next  = b_mag_in;
               end else begin
                  lo_next = b_mag_in;
                  m_next  = a_mag_in;
               end
               if (special_in) begin
                  result_next = special_val;
                  zero_next   = ~|special_val;
               end
            end
         end
         CALC: begin
            cnt_next = cnt_reg - CW'(1);
            if (op_reg[2]) begin
               // Restoring division: keep the trial difference only when it did not borrow.
               if (!div_trial[N]) begin
                  hi_next = div_trial[N-1:0];
                  lo_next = {lo_reg[N-2:0], 1'b1};
               end else begin
                  hi_next = {hi_reg[N-2:0], lo_reg[N-1]};
                  lo_next = {lo_reg[N-2:0], 1'b0};
               end
            end else begin
               hi_next = mul_sum[N:1];
               lo_next = {mul_sum[0], lo_reg[N-1:1]};
            end
         end
         FIX: begin
            result_next = fix_val;
            zero_next   = ~|fix_val;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hi_reg     <= '0;
         lo_reg     <= '0;
         m_reg      <= '0;
         cnt_reg    <= '0;
         op_reg     <= '0;
         neg_reg    <= 1'b0;
         result_reg <= '0;
         zero_reg   <= 1'b0;
      end else begin
         hi_reg     <= hi_next;
         lo_reg     <= lo_next;
         m_reg      <= m_next;
         cnt_reg    <= cnt_next;
         op_reg     <= op_next;
         neg_reg    <= neg_next;
         result_reg <= result_next;
         zero_reg   <= zero_next;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept) state_next = special_in ? DONE : CALC;
         CALC: if (cnt_reg == CW'(1)) state_next = FIX;
         FIX:  state_next = DONE;
         DONE: if (ready_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ready_o    = (state_reg == IDLE);
      valid_o    = (state_reg == DONE);
      busy_o     = (state_reg == CALC) | (state_reg == FIX);
      result_o   = result_reg;
      zeroflag_o = zero_reg;
   end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed vector bench for alu_muldiv_seq (N=32): results, zero flag, latency,
// asynchronous abort and result back-pressure.
module tb_alu_muldiv_seq;

   localparam int N = 32;
   localparam int LAT_ITER = N + 1;
   localparam int NV = 28;

   localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
   localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

   logic         clk_i = 1'b0;
   logic         rst_n_i = 1'b0;
   logic         valid_i = 1'b0;
   logic         ready_o;
   logic [N-1:0] a_i = '0;
   logic [N-1:0] b_i = '0;
   logic [2:0]   operacion_i = '0;
   logic         valid_o;
   logic         ready_i = 1'b1;
   logic [N-1:0] result_o;
   logic         zeroflag_o;
   logic         busy_o;

   int n_applied = 0;
   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      logic [2:0]   op;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] exp;
      logic         spec;
   } vec_t;

   vec_t vecs[NV];

   alu_muldiv_seq #(.N(N)) dut (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .a_i        (a_i),
      .b_i        (b_i),
      .operacion_i(operacion_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .result_o   (result_o),
      .zeroflag_o (zeroflag_o),
      .busy_o     (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ready();
      int w;
      w = 0;
      @(negedge clk_i);
      while (!ready_o && w < 200) begin
         @(negedge clk_i);
         w++;
      end
      if (w >= 200) begin
         n_checks++;
         n_fail++;
         $display("FAIL ready timeout: got ready_o=0, expected 1 within 200 cycles");
      end
   endtask

   // Drives one request, then counts rising edges after the accepting edge until valid_o.
   task automatic run_op(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] res, output logic zf, output int lat);
      wait_ready();
      operacion_i = op;
      a_i         = a;
      b_i         = b;
      valid_i     = 1'b1;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      lat = 0;
      while (!valid_o && lat < 200) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      res = result_o;
      zf  = zeroflag_o;
   endtask

   initial begin
      logic [N-1:0] res;
      logic         zf;
      int           lat;
      logic         seen;

      vecs[0]  = '{OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
      vecs[1]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
      vecs[2]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
      vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
      vecs[4]  = '{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0};
      vecs[5]  = '{OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0};
      vecs[6]  = '{OP_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, 1'b0};
      vecs[7]  = '{OP_REMU,   32'h00000064, 32'h00000007, 32'h00000002, 1'b0};
      vecs[8]  = '{OP_DIV,    32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b1};
      vecs[9]  = '{OP_REM,    32'h00000005, 32'h00000000, 32'h00000005, 1'b1};
      vecs[10] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
      vecs[11] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
      vecs[12] = '{OP_DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b1};
      vecs[13] = '{OP_REMU,   32'h00000009, 32'h00000000, 32'h00000009, 1'b1};
      vecs[14] = '{OP_MULH,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0};
      vecs[15] = '{OP_MUL,    32'h00000000, 32'h00000123, 32'h00000000, 1'b0};
      vecs[16] = '{OP_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
      vecs[17] = '{OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[18] = '{OP_REM,    32'hFFFFFFF8, 32'h00000004, 32'h00000000, 1'b0};
      vecs[19] = '{OP_DIVU,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0};
      vecs[20] = '{OP_DIV,    32'h80000000, 32'h00000002, 32'hC0000000, 1'b0};
      vecs[21] = '{OP_REMU,   32'h00000007, 32'h0000000A, 32'h00000007, 1'b0};
      vecs[22] = '{OP_MULHSU, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 1'b0};
      vecs[23] = '{OP_MUL,    32'h00010000, 32'h00010000, 32'h00000000, 1'b0};
      vecs[24] = '{OP_MULHU,  32'h80000000, 32'h00000004, 32'h00000002, 1'b0};
      vecs[25] = '{OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0};
      vecs[26] = '{OP_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0};
      vecs[27] = '{OP_DIV,    32'h80000000, 32'h00000001, 32'h80000000, 1'b0};

      // Reset state
      #1;
      check("reset ready_o", 64'(ready_o), 64'd1);
      check("reset valid_o", 64'(valid_o), 64'd0);
      check("reset busy_o", 64'(busy_o), 64'd0);
      check("reset result_o", 64'(result_o), 64'd0);
      check("reset zeroflag_o", 64'(zeroflag_o), 64'd0);
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;

      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, zf, lat);
         n_applied++;
         check($sformatf("vec%0d result", i), 64'(res), 64'(vecs[i].exp));
         check($sformatf("vec%0d zeroflag", i), 64'(zf), 64'(vecs[i].exp == '0));
         check($sformatf("vec%0d latency", i), 64'(lat), vecs[i].spec ? 64'd0 : 64'(LAT_ITER));
         $display("vec%0d op=%0d a=%h b=%h -> result=%h zf=%0d lat=%0d", i, vecs[i].op,
                  vecs[i].a, vecs[i].b, res, zf, lat);
      end

      // Asynchronous reset in the middle of an iteration aborts it
      wait_ready();
      operacion_i = OP_MULHU;
      a_i         = 32'hFFFFFFFF;
      b_i         = 32'hFFFFFFFF;
      valid_i     = 1'b1;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      repeat (5) @(posedge clk_i);
      #3;
      check("busy before abort", 64'(busy_o), 64'd1);
      rst_n_i = 1'b0;
      #1;
      check("abort ready_o", 64'(ready_o), 64'd1);
      check("abort valid_o", 64'(valid_o), 64'd0);
      check("abort busy_o", 64'(busy_o), 64'd0);
      check("abort result_o", 64'(result_o), 64'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk_i);
         #1;
         if (valid_o) seen = 1'b1;
      end
      n_applied++;
      check("abort no result", 64'(seen), 64'd0);
      $display("abort: valid seen=%0d ready_o=%0d", seen, ready_o);

      // Result back-pressure; requests during DONE must be ignored
      ready_i = 1'b0;
      run_op(OP_DIVU, 32'd100, 32'd7, res, zf, lat);
      n_applied++;
      check("bp result", 64'(res), 64'hE);
      check("bp latency", 64'(lat), 64'(LAT_ITER));
      @(negedge clk_i);
      operacion_i = OP_DIV;
      a_i         = 32'd1;
      b_i         = 32'd0;
      valid_i     = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk_i);
         #1;
         check($sformatf("bp hold valid c%0d", c), 64'(valid_o), 64'd1);
         check($sformatf("bp hold result c%0d", c), 64'(result_o), 64'hE);
         check($sformatf("bp hold ready c%0d", c), 64'(ready_o), 64'd0);
      end
      $display("backpressure: held result=%h valid=%0d ready=%0d", result_o, valid_o, ready_o);

      @(negedge clk_i);
      ready_i     = 1'b1;
      operacion_i = OP_MUL;
      a_i         = 32'd3;
      b_i         = 32'd5;
      @(posedge clk_i);
      #1;
      check("handoff ready_o", 64'(ready_o), 64'd1);
      check("handoff valid_o", 64'(valid_o), 64'd0);
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      check("b2b accepted busy", 64'(busy_o), 64'd1);
      lat = 0;
      while (!valid_o && lat < 200) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      n_applied++;
      check("b2b result", 64'(result_o), 64'd15);
      check("b2b latency", 64'(lat), 64'(LAT_ITER));
      $display("back-to-back: MUL 3*5 -> result=%h lat=%0d", result_o, lat);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
      $finish;
   end

endmodule
